// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: fetch-control bundle between the ID stage / hazard unit /
// instruction memory and the fetch sequencer, plus the PC/NPC datapath enables.
// master: the sequencer (pc_fetch_ctrl). slave: the surrounding pipeline.
interface pc_fetch_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();
    // requests into the sequencer
    logic             branch_taken;
    logic             jump;
    logic             hazard_stall;
    logic             imem_ready;

    // controls out of the sequencer
    logic             imem_req;
    logic             pc_le;
    logic             npc_le;
    logic             if_id_le;
    logic             target_le;
    logic [1:0]       pc_source_select;
    logic [1:0]       fetch_state;
    logic [CNT_W-1:0] stall_count;

    modport master (
        input  branch_taken,
        input  jump,
        input  hazard_stall,
        input  imem_ready,
        output imem_req,
        output pc_le,
        output npc_le,
        output if_id_le,
        output target_le,
        output pc_source_select,
        output fetch_state,
        output stall_count
    );

    modport slave (
        output branch_taken,
        output jump,
        output hazard_stall,
        output imem_ready,
        input  imem_req,
        input  pc_le,
        input  npc_le,
        input  if_id_le,
        input  target_le,
        input  pc_source_select,
        input  fetch_state,
        input  stall_count
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage sequencer owning PC/NPC/IF-ID load enables and the
// next-PC source select. Holds fetch for RESET_HOLD_CYCLES after reset, then
// advances whenever memory is ready and no hazard stall is raised. A redirect
// that cannot be applied immediately is remembered until the next advance.
// Enables/select are Mealy outputs of registered state and current inputs.
// Optional feature macro: PC_STALL_COUNTER_EN builds the saturating stall counter;
// without it stall_count is tied to zero.
module pc_fetch_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES = 2,
    parameter int unsigned CNT_W             = 16
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_ctrl_if.master bus
);

    localparam int unsigned HOLD_W =
        (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [1:0]        SEL_NPC    = 2'b00;
    localparam logic [1:0]        SEL_TARGET = 2'b01;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'b00,
        ST_FETCH    = 2'b01,
        ST_WAIT_MEM = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pending_q, pending_d;

    logic              redirect_c;
    logic              active_c;
    logic              advance_c;

    // Sequencer state, post-reset hold counter and remembered redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pending_q  <= pending_d;
        end
    end

    // Next-state, pending tracking and Mealy fetch controls
    always_comb begin
        state_d              = state_q;
        hold_cnt_d           = hold_cnt_q;
        pending_d            = pending_q;
        bus.imem_req         = 1'b0;
        bus.pc_le            = 1'b0;
        bus.npc_le           = 1'b0;
        bus.if_id_le         = 1'b0;
        bus.target_le        = 1'b0;
        bus.pc_source_select = SEL_NPC;
        bus.fetch_state      = state_q;

        redirect_c = bus.branch_taken | bus.jump;
        active_c   = (state_q == ST_FETCH) || (state_q == ST_WAIT_MEM);
        advance_c  = active_c && bus.imem_ready && !bus.hazard_stall;

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_FETCH;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_FETCH: begin
                if (!bus.imem_ready) begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (advance_c) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase

        if (active_c) begin
            bus.imem_req  = 1'b1;
            // Only the first redirect of an unapplied pair captures its target
            bus.target_le = redirect_c && !pending_q;
            if (advance_c) begin
                bus.pc_le    = 1'b1;
                bus.npc_le   = 1'b1;
                bus.if_id_le = 1'b1;
                bus.pc_source_select = (pending_q || redirect_c) ? SEL_TARGET : SEL_NPC;
                pending_d    = 1'b0;
            end else if (redirect_c) begin
                pending_d    = 1'b1;
            end
        end
    end

`ifdef PC_STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of fetch cycles that did not advance
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (active_c && !advance_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.stall_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table, hand-written reset sequences and
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pc_fetch_ctrl;

    localparam int unsigned RHC   = 2;
    localparam int unsigned CNT_W = 16;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef PC_STALL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    pc_fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pc_fetch_ctrl #(
        .RESET_HOLD_CYCLES(RHC),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: cycles since reset, remembered redirect, waiting flag
    int m_cyc;
    bit m_pend;
    bit m_wait;
    int m_stall;

    typedef struct {
        logic       bt;
        logic       j;
        logic       hs;
        logic       rdy;
        logic [8:0] exp;
        int         cnt;
    } vec_t;

    vec_t tbl[27];

    // {imem_req, pc_le, npc_le, if_id_le, target_le, select[1:0], state[1:0]}
    function automatic logic [8:0] pack(input logic req, input logic le, input logic tle,
                                        input int sel, input int st);
        return {req, le, le, le, tle, 2'(sel), 2'(st)};
    endfunction

    function automatic vec_t mk(input logic bt, input logic j, input logic hs, input logic rdy,
                                input logic req, input logic le, input logic tle,
                                input int sel, input int st, input int cnt);
        vec_t v;
        v.bt = bt; v.j = j; v.hs = hs; v.rdy = rdy;
        v.exp = pack(req, le, tle, sel, st);
        v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [8:0] dut_out();
        return {bus.imem_req, bus.pc_le, bus.npc_le, bus.if_id_le, bus.target_le,
                bus.pc_source_select, bus.fetch_state};
    endfunction

    function automatic logic [8:0] model_out(input logic bt, input logic j,
                                             input logic hs, input logic rdy);
        bit fetching = (m_cyc >= int'(RHC));
        bit redir    = bt | j;
        bit adv      = fetching && rdy && !hs;
        int st       = !fetching ? 0 : (m_wait ? 2 : 1);
        return pack(fetching, adv, fetching && redir && !m_pend,
                    (adv && (m_pend || redir)) ? 1 : 0, st);
    endfunction

    function automatic int model_cnt();
        return CNT_EN ? m_stall : 0;
    endfunction

    task automatic model_step(input logic bt, input logic j, input logic hs, input logic rdy);
        bit fetching = (m_cyc >= int'(RHC));
        bit adv      = fetching && rdy && !hs;
        if (fetching) begin
            if (adv) begin
                m_pend = 1'b0;
                m_wait = 1'b0;
            end else begin
                if (bt | j) m_pend = 1'b1;
                if (!rdy)   m_wait = 1'b1;
                if (m_stall < CNT_MAX) m_stall++;
            end
        end
        if (m_cyc < int'(RHC)) m_cyc++;
    endtask

    task automatic model_reset();
        m_cyc = 0; m_pend = 1'b0; m_wait = 1'b0; m_stall = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: entered at posedge+1, returns at next posedge+1
    task automatic cycle(input logic bt, input logic j, input logic hs, input logic rdy,
                         input string tag, output logic [8:0] act, output int act_cnt);
        bus.branch_taken = bt;
        bus.jump         = j;
        bus.hazard_stall = hs;
        bus.imem_ready   = rdy;
        #3;
        act     = dut_out();
        act_cnt = int'(bus.stall_count);
        check($sformatf("%s model outs", tag), 32'(act), 32'(model_out(bt, j, hs, rdy)));
        check($sformatf("%s model cnt", tag), 32'(act_cnt), 32'(model_cnt()));
        @(posedge clk);
        model_step(bt, j, hs, rdy);
        #1;
    endtask

    // Asynchronous reset pulse: entered and left at posedge+1
    task automatic do_reset(input string tag);
        bus.branch_taken = 1'b1;
        bus.jump         = 1'b1;
        bus.hazard_stall = 1'b0;
        bus.imem_ready   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check($sformatf("%s async outs", tag), 32'(dut_out()), 32'(0));
        check($sformatf("%s async cnt", tag), 32'(bus.stall_count), 32'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("%s held outs", tag), 32'(dut_out()), 32'(0));
        reset = 1'b1;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] act;
        int         act_cnt;

        //            bt j  hs rdy req le tle sel st cnt
        tbl[0]  = mk(0, 0, 0, 1,  0,  0, 0,  0,  0, 0);
        tbl[1]  = mk(1, 0, 0, 1,  0,  0, 0,  0,  0, 0);
        tbl[2]  = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 0);
        tbl[3]  = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 0);
        tbl[4]  = mk(1, 0, 0, 1,  1,  1, 1,  1,  1, 0);
        tbl[5]  = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 0);
        tbl[6]  = mk(0, 1, 1, 1,  1,  0, 1,  0,  1, 0);
        tbl[7]  = mk(0, 0, 1, 1,  1,  0, 0,  0,  1, 1);
        tbl[8]  = mk(0, 0, 1, 1,  1,  0, 0,  0,  1, 2);
        tbl[9]  = mk(0, 0, 0, 1,  1,  1, 0,  1,  1, 3);
        tbl[10] = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 3);
        tbl[11] = mk(0, 0, 0, 0,  1,  0, 0,  0,  1, 3);
        tbl[12] = mk(0, 0, 0, 0,  1,  0, 0,  0,  2, 4);
        tbl[13] = mk(0, 0, 0, 0,  1,  0, 0,  0,  2, 5);
        tbl[14] = mk(0, 0, 0, 0,  1,  0, 0,  0,  2, 6);
        tbl[15] = mk(0, 0, 0, 1,  1,  1, 0,  0,  2, 7);
        tbl[16] = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 7);
        tbl[17] = mk(0, 1, 1, 1,  1,  0, 1,  0,  1, 7);
        tbl[18] = mk(1, 0, 1, 1,  1,  0, 0,  0,  1, 8);
        tbl[19] = mk(0, 0, 0, 1,  1,  1, 0,  1,  1, 9);
        tbl[20] = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 9);
        tbl[21] = mk(1, 1, 0, 1,  1,  1, 1,  1,  1, 9);
        tbl[22] = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 9);
        tbl[23] = mk(0, 0, 0, 0,  1,  0, 0,  0,  1, 9);
        tbl[24] = mk(0, 0, 1, 1,  1,  0, 0,  0,  2, 10);
        tbl[25] = mk(0, 0, 0, 1,  1,  1, 0,  0,  2, 11);
        tbl[26] = mk(0, 0, 0, 1,  1,  1, 0,  0,  1, 11);

        reset            = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        bus.hazard_stall = 1'b0;
        bus.imem_ready   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("initial");

        // Directed vector table
        for (int i = 0; i < 27; i++) begin
            cycle(tbl[i].bt, tbl[i].j, tbl[i].hs, tbl[i].rdy, $sformatf("vec%0d", i), act, act_cnt);
            check($sformatf("vec%0d outs", i), 32'(act), 32'(tbl[i].exp));
            check($sformatf("vec%0d cnt", i), 32'(act_cnt), 32'(CNT_EN ? tbl[i].cnt : 0));
        end

        // Reset while in WAIT_MEM with a remembered redirect
        cycle(0, 1, 1, 1, "pre_rst0", act, act_cnt);
        check("pre_rst0 target_le", 32'(act[4]), 32'(1));
        cycle(0, 0, 0, 0, "pre_rst1", act, act_cnt);
        cycle(0, 0, 1, 0, "pre_rst2", act, act_cnt);
        check("pre_rst2 state", 32'(act[1:0]), 32'(2));
        do_reset("midwait");
        cycle(0, 0, 0, 1, "post_rst0", act, act_cnt);
        check("post_rst0 req", 32'(act[8]), 32'(0));
        cycle(0, 0, 0, 1, "post_rst1", act, act_cnt);
        check("post_rst1 req", 32'(act[8]), 32'(0));
        cycle(0, 0, 0, 1, "post_rst2", act, act_cnt);
        check("post_rst2 outs", 32'(act), 32'(pack(1, 1, 0, 0, 1)));
        check("post_rst2 cnt", 32'(act_cnt), 32'(0));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($sformatf("rnd_rst%0d", n));
            end else begin
                cycle(logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 7) == 0),
                      logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) != 0),
                      $sformatf("rnd%0d", n), act, act_cnt);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
